// File: rtl/encoder_fixed_point_seq_pkg.sv
// Shared types and sizing helpers for the sequential fixed-point encoder layer.
package encoder_fp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int FRAC_DEFAULT = 26;

   // Wide enough that N_INPUT full-width products plus a shifted bias never overflow.
   function automatic int acc_width(input int bitsize, input int n_input);
      return 2 * bitsize + $clog2(n_input) + 1;
   endfunction

   function automatic longint sat_max(input int bitsize);
      return (longint'(1) <<< (bitsize - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int bitsize);
      return -(longint'(1) <<< (bitsize - 1));
   endfunction

endpackage

// File: rtl/encoder_fixed_point_seq_if.sv
// Job-in / result-out handshake bundle for the sequential encoder layer.
interface encoder_fixed_point_seq_if #(
   parameter int N_INPUT  = 9,
   parameter int M_OUTPUT = 4,
   parameter int BITSIZE  = 32
);
   logic                                  in_valid;
   logic                                  in_ready;
   logic [N_INPUT*BITSIZE-1:0]            x;
   logic [N_INPUT*M_OUTPUT*BITSIZE-1:0]   w;
   logic [M_OUTPUT*BITSIZE-1:0]           b;
   logic                                  relu_en;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [M_OUTPUT*BITSIZE-1:0]           out;
   logic [M_OUTPUT-1:0]                   sat;

   modport master (
      output in_valid, x, w, b, relu_en, out_ready,
      input  in_ready, out_valid, out, sat
   );

   modport slave (
      input  in_valid, x, w, b, relu_en, out_ready,
      output in_ready, out_valid, out, sat
   );
endinterface

// File: rtl/encoder_fixed_point_seq_round_sat.sv
// Converts a wide accumulator to a BITSIZE word: round half toward +inf, clamp, optional ReLU.
module fp_round_sat
   import encoder_fp_pkg::*;
#(
   parameter int IN_W    = 69,
   parameter int BITSIZE = 32,
   parameter int FRAC    = FRAC_DEFAULT
) (
   input  logic signed [IN_W-1:0] acc_i,
   input  logic                   relu_en_i,
   output logic [BITSIZE-1:0]     word_o,
   output logic                   sat_o
);
   localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(1) <<< (FRAC - 1);
   localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(sat_max(BITSIZE));
   localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(sat_min(BITSIZE));

   logic signed [IN_W:0] sum;
   logic signed [IN_W:0] r;

   always_comb begin
      sum    = (IN_W+1)'(acc_i) + HALF;
      r      = sum >>> FRAC;
      sat_o  = 1'b0;
      word_o = r[BITSIZE-1:0];
      if (r > SAT_MAX) begin
         word_o = SAT_MAX[BITSIZE-1:0];
         sat_o  = 1'b1;
      end else if (r < SAT_MIN) begin
         word_o = SAT_MIN[BITSIZE-1:0];
         sat_o  = 1'b1;
      end
      // ReLU acts on the clamped value and leaves the saturation flag alone.
      if (relu_en_i && word_o[BITSIZE-1]) begin
         word_o = '0;
      end
   end
endmodule

// File: rtl/encoder_fixed_point_seq.sv
// Sequential fixed-point encoder layer: one MAC, time-multiplexed over N_INPUT x M_OUTPUT terms.
//   state   | meaning
//   IDLE    | in_ready=1, waiting for a job
//   MAC     | one x[i]*w[j][i] term per cycle, channel j written when i wraps
//   DONE    | out_valid=1, results held until out_ready
module encoder_fixed_point_seq
   import encoder_fp_pkg::*;
#(
   parameter int N_INPUT  = 9,
   parameter int M_OUTPUT = 4,
   parameter int BITSIZE  = 32,
   parameter int FRAC     = FRAC_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   encoder_fixed_point_seq_if.slave    bus
);
   localparam int ACC_W = acc_width(BITSIZE, N_INPUT);
   localparam int IW    = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1;
   localparam int JW    = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(N_INPUT - 1);
   localparam logic [JW-1:0] J_LAST = JW'(M_OUTPUT - 1);

   state_t                              state_q, state_d;
   logic [IW-1:0]                       i_q, i_d;
   logic [JW-1:0]                       j_q, j_d, j_nxt;
   logic signed [ACC_W-1:0]             acc_q, acc_d, acc_next;
   logic [N_INPUT*BITSIZE-1:0]          x_q, x_d;
   logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w_q, w_d;
   logic [M_OUTPUT*BITSIZE-1:0]         b_q, b_d;
   logic                                relu_q, relu_d;
   logic [M_OUTPUT*BITSIZE-1:0]         out_q, out_d;
   logic [M_OUTPUT-1:0]                 sat_q, sat_d;
   logic signed [2*BITSIZE-1:0]         prod;
   logic [BITSIZE-1:0]                  rs_word;
   logic                                rs_sat;

   function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [BITSIZE-1:0] v);
      return ACC_W'(v) <<< FRAC;
   endfunction

   always_comb begin
      prod     = $signed(x_q[i_q*BITSIZE +: BITSIZE]) *
                 $signed(w_q[(j_q*N_INPUT + i_q)*BITSIZE +: BITSIZE]);
      acc_next = acc_q + ACC_W'(prod);
      j_nxt    = j_q + 1'b1;
   end

   fp_round_sat #(
      .IN_W    (ACC_W),
      .BITSIZE (BITSIZE),
      .FRAC    (FRAC)
   ) u_round_sat (
      .acc_i     (acc_next),
      .relu_en_i (relu_q),
      .word_o    (rs_word),
      .sat_o     (rs_sat)
   );

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      acc_d   = acc_q;
      x_d     = x_q;
      w_d     = w_q;
      b_d     = b_q;
      relu_d  = relu_q;
      out_d   = out_q;
      sat_d   = sat_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.x;
               w_d     = bus.w;
               b_d     = bus.b;
               relu_d  = bus.relu_en;
               i_d     = '0;
               j_d     = '0;
               acc_d   = bias_ext(bus.b[0 +: BITSIZE]);
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            if (i_q == I_LAST) begin
               out_d[j_q*BITSIZE +: BITSIZE] = rs_word;
               sat_d[j_q] = rs_sat;
               i_d        = '0;
               if (j_q == J_LAST) begin
                  acc_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  j_d   = j_nxt;
                  acc_d = bias_ext(b_q[j_nxt*BITSIZE +: BITSIZE]);
               end
            end else begin
               acc_d = acc_next;
               i_d   = i_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         w_q     <= '0;
         b_q     <= '0;
         relu_q  <= 1'b0;
         out_q   <= '0;
         sat_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         w_q     <= w_d;
         b_q     <= b_d;
         relu_q  <= relu_d;
         out_q   <= out_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out       = out_q;
   assign bus.sat       = sat_q;
endmodule

// File: tb/tb_encoder_fixed_point_seq.sv
// Scoreboard bench for encoder_fixed_point_seq: model results queued at accept, compared at out_valid.
module tb_encoder_fixed_point_seq;
   localparam int N  = 9;
   localparam int M  = 4;
   localparam int B  = 32;
   localparam int FR = 26;
   localparam int LAT = N * M;

   typedef struct {
      logic [M*B-1:0] o;
      logic [M-1:0]   s;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];

   encoder_fixed_point_seq_if #(.N_INPUT(N), .M_OUTPUT(M), .BITSIZE(B)) bus_if ();

   encoder_fixed_point_seq #(
      .N_INPUT  (N),
      .M_OUTPUT (M),
      .BITSIZE  (B),
      .FRAC     (FR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [N*B-1:0] xv, input logic [N*M*B-1:0] wv,
                                  input logic [M*B-1:0] bv, input logic relu);
      exp_t e;
      logic signed [127:0] s, xi, wi, bj;
      logic signed [127:0] hi, lo;
      hi = (128'sd1 <<< (B - 1)) - 1;
      lo = -(128'sd1 <<< (B - 1));
      e.o = '0;
      e.s = '0;
      for (int j = 0; j < M; j++) begin
         bj = $signed(bv[j*B +: B]);
         s  = bj <<< FR;
         for (int i = 0; i < N; i++) begin
            xi = $signed(xv[i*B +: B]);
            wi = $signed(wv[(j*N + i)*B +: B]);
            s  = s + xi * wi;
         end
         s = (s + (128'sd1 <<< (FR - 1))) >>> FR;
         if (s > hi) begin s = hi; e.s[j] = 1'b1; end
         else if (s < lo) begin s = lo; e.s[j] = 1'b1; end
         if (relu && s < 0) s = 0;
         e.o[j*B +: B] = s[B-1:0];
      end
      return e;
   endfunction

   task automatic idle_bus();
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
   endtask

   // Accepts one job, checks latency and result; hold>0 exercises backpressure and busy pokes.
   task automatic run_job(input string tag, input logic [N*B-1:0] xv, input logic [N*M*B-1:0] wv,
                          input logic [M*B-1:0] bv, input logic relu, input int hold);
      exp_t e;
      int   cnt;
      @(negedge clk);
      bus_if.x        = xv;
      bus_if.w        = wv;
      bus_if.b        = bv;
      bus_if.relu_en  = relu;
      bus_if.in_valid = 1'b1;
      chk({tag, "_in_ready_pre"}, bus_if.in_ready, 1'b1);
      @(posedge clk);
      sb.push_back(model(xv, wv, bv, relu));
      #1;
      bus_if.in_valid = 1'b0;
      cnt = 0;
      while (bus_if.out_valid !== 1'b1 && cnt < 100) begin
         if (hold > 0 && cnt == 5) begin
            chk({tag, "_busy_in_ready"}, bus_if.in_ready, 1'b0);
            bus_if.in_valid = 1'b1;
            bus_if.x        = ~xv;
            bus_if.w        = ~wv;
         end
         @(posedge clk);
         #1;
         bus_if.in_valid = 1'b0;
         cnt++;
      end
      chk({tag, "_latency"}, 128'(cnt), 128'(LAT));
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1'b1, 1'b0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_out"}, bus_if.out, e.o);
      chk({tag, "_sat"}, bus_if.sat, e.s);
      for (int k = 0; k < hold; k++) begin
         if (k == 3) bus_if.in_valid = 1'b1;
         @(posedge clk);
         #1;
         bus_if.in_valid = 1'b0;
         chk({tag, "_hold_valid"}, bus_if.out_valid, 1'b1);
         chk({tag, "_hold_out"}, bus_if.out, e.o);
         chk({tag, "_hold_sat"}, bus_if.sat, e.s);
         chk({tag, "_hold_in_ready"}, bus_if.in_ready, 1'b0);
      end
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b0;
      chk({tag, "_drain_valid"}, bus_if.out_valid, 1'b0);
      chk({tag, "_drain_in_ready"}, bus_if.in_ready, 1'b1);
   endtask

   logic [N*B-1:0]   xv;
   logic [N*M*B-1:0] wv;
   logic [M*B-1:0]   bv;
   exp_t             ez;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      idle_bus();
      bus_if.x       = '0;
      bus_if.w       = '0;
      bus_if.b       = '0;
      bus_if.relu_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", bus_if.in_ready, 1'b1);
      chk("rst_out_valid", bus_if.out_valid, 1'b0);
      chk("rst_out", bus_if.out, '0);
      chk("rst_sat", bus_if.sat, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: all ones -> 9.0 per channel
      xv = {N{32'h0400_0000}};
      wv = {N*M{32'h0400_0000}};
      bv = '0;
      ez = model(xv, wv, bv, 1'b0);
      chk("model_basic", ez.o[31:0], 32'h2400_0000);
      run_job("basic", xv, wv, bv, 1'b0, 0);

      // 2: saturation both directions
      xv = {N{32'h4000_0000}};
      wv = '0;
      for (int i = 0; i < N; i++) begin
         wv[(0*N + i)*B +: B] = 32'h4000_0000;
         wv[(1*N + i)*B +: B] = 32'hC000_0000;
      end
      ez = model(xv, wv, bv, 1'b0);
      chk("model_sat", {ez.s, ez.o[63:0]}, {4'b0011, 32'h8000_0000, 32'h7FFF_FFFF});
      run_job("sat", xv, wv, bv, 1'b0, 0);

      // 3: ReLU off / on
      xv = {N{32'h0400_0000}};
      wv = {N*M{32'hFC00_0000}};
      ez = model(xv, wv, bv, 1'b0);
      chk("model_neg", ez.o[31:0], 32'hDC00_0000);
      run_job("neg", xv, wv, bv, 1'b0, 0);
      run_job("relu", xv, wv, bv, 1'b1, 0);

      // 4: rounding half toward +inf
      xv = {N{32'h0200_0000}};
      wv = {N*M{32'h0000_0001}};
      ez = model(xv, wv, bv, 1'b0);
      chk("model_rnd_pos", ez.o[31:0], 32'h0000_0005);
      run_job("rnd_pos", xv, wv, bv, 1'b0, 0);
      wv = {N*M{32'hFFFF_FFFF}};
      ez = model(xv, wv, bv, 1'b0);
      chk("model_rnd_neg", ez.o[31:0], 32'hFFFF_FFFC);
      run_job("rnd_neg", xv, wv, bv, 1'b0, 0);

      // nonzero bias, mixed channels
      xv = {N{32'h0400_0000}};
      wv = {N*M{32'h0100_0000}};
      bv = {32'hF800_0000, 32'h0000_0003, 32'h0400_0000, 32'h0000_0000};
      run_job("bias", xv, wv, bv, 1'b1, 0);

      // 5: backpressure with busy pokes
      bv = '0;
      wv = {N*M{32'h0400_0000}};
      run_job("bp", xv, wv, bv, 1'b0, 10);
      repeat (4) @(posedge clk);
      #1;
      chk("bp_no_queued_job", bus_if.in_ready, 1'b1);
      chk("bp_no_extra_out", bus_if.out_valid, 1'b0);

      // random jobs
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) xv[i*B +: B] = $urandom;
         for (int i = 0; i < N*M; i++) wv[i*B +: B] = $urandom;
         for (int i = 0; i < M; i++) bv[i*B +: B] = $urandom;
         run_job("rand", xv, wv, bv, 1'($urandom_range(0, 1)), 0);
      end

      // 6: reset mid-job
      xv = {N{32'h0400_0000}};
      wv = {N*M{32'hFC00_0000}};
      bv = '0;
      @(negedge clk);
      bus_if.x        = xv;
      bus_if.w        = wv;
      bus_if.b        = bv;
      bus_if.relu_en  = 1'b0;
      bus_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus_if.out_valid, 1'b0);
      chk("midrst_out", bus_if.out, '0);
      chk("midrst_sat", bus_if.sat, '0);
      chk("midrst_in_ready", bus_if.in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      wv = {N*M{32'h0400_0000}};
      run_job("post_rst", xv, wv, bv, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
